fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-style floating-point multiplier with valid/ready handshaking, special-value handling, round-to-nearest-even and a full exception flag set. It generalises the single-cycle bfloat16 multiplier to any exponent/mantissa split. It sits between the FPU operand-issue stage and the result writeback/arbiter, and can stall on writeback backpressure.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 7, stored mantissa field width (≥2); word width W = 1+EXP_W+MAN_W (default 16, bfloat16)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset (one clock; synchronous active-high)
- in_valid  input  1  operand pair valid
- in_ready  output  1  multiplier accepts operands this cycle
- opA, opB  input  W  operands {sign, exp, man}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- product  output  W  result
- overflow, underflow, inexact, invalid  output  1 each  exception flags, qualified by out_valid

## Operation
- BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1 (all-ones exponent).
- Input classes: exp==0 → zero (subnormals flushed, sign kept); exp==EMAX, man≠0 → NaN; exp==EMAX, man==0 → inf; else normal with hidden 1.
- Sign = sA^sB for all non-NaN results.
- Specials (priority order): any NaN or inf×zero → canonical qNaN {0, EMAX, 1 followed by MAN_W-1 zeros}, invalid=1 only for inf×zero or signalling NaN (man MSB 0); inf×nonzero → ±inf, no flags; zero×finite → ±0, no flags.
- Normal path: mantissa product 2(MAN_W+1) bits, unsigned; exponent sum computed in EXP_W+2 signed bits: e = eA+eB-BIAS, +1 if product MSB set (normalise right by one).
- Rounding: guard = first discarded bit, sticky = OR of remaining discarded bits; round up iff guard & (sticky | LSB). Mantissa carry-out from rounding increments e and renormalises.
- After rounding: e ≥ EMAX → ±inf, overflow=1, inexact=1. e ≤ 0 → ±0 (flush-to-zero), underflow=1, inexact=1. Else inexact = guard|sticky.
- Flags are per-result, not sticky; the accumulating FCSR lives elsewhere.

## Timing
- 3-stage pipeline: S1 unpack/classify + mantissa multiply; S2 exponent add + normalise + guard/sticky; S3 round + overflow/underflow + pack.
- Latency 3 cycles from accepted input to out_valid with out_ready held high; throughput 1/cycle.
- Global stall: advance = !out_valid | out_ready; in_ready = advance. Transfer on in_valid&in_ready; in-flight bubbles carry valid=0.
- While out_valid & !out_ready: product and flags held bit-stable; no stage advances; in_ready=0.
- in_ready is a function of out_valid and out_ready only; in_ready never depends on in_valid.
- Reset: all stage valids 0, out_valid=0, product=0, all flags 0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards in-flight operations with no output.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even as above.
- Not defined: truncate (never round up, no rounding carry); guard/sticky are still computed for inexact, and overflow/underflow detection is unchanged.

## Test plan
- Basic (bf16): 0x3FC0×0x3FC0 (1.5×1.5) → 0x4010, all flags 0, out_valid exactly 3 cycles after acceptance.
- Tie rounding: 0x3F81×0x3FC0 → 0x3FC2 with FP_MUL_RNE_EN, 0x3FC1 without; inexact=1 in both builds.
- Overflow/underflow: 0x7F00×0x4000 → 0x7F80, overflow=1, inexact=1. 0x0080×0x3F00 → 0x0000, underflow=1, inexact=1.
- Specials: 0x7F80×0x0000 → 0x7FC0 with invalid=1; 0xFF80×0x4000 → 0xFF80 with no flags; 0x7FC1×0x3F80 → 0x7FC0 with invalid=0.
- Backpressure: stream 6 back-to-back ops, drop out_ready for 4 cycles mid-stream → in_ready=0 and product held stable while stalled; all 6 results arrive in order, none lost or duplicated.
- Reset mid-flight: assert reset with 3 ops in the pipe → out_valid=0 the next cycle and no stale results appear afterwards; repeat at EXP_W=5, MAN_W=10 (fp16): 0x3C00×0x4000 → 0x4000.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-style FP multiplier (flush-to-zero); define FP_MUL_RNE_EN for round-to-nearest-even, else truncate.
// Latency 3 cycles, throughput 1/cycle.
// Backpressure: one global stall; every stage holds while out_valid & !out_ready, in_ready = !out_valid | out_ready.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] opA,
   input  logic [EXP_W+MAN_W:0] opB,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] product,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact,
   output logic                 invalid
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * (MAN_W + 1);
   localparam int SW = EXP_W + 2;
   localparam logic signed [SW-1:0] BIAS_S = SW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [SW-1:0] EMAX_S = SW'((1 << EXP_W) - 1);
   localparam logic signed [SW-1:0] ZERO_S = '0;
   localparam logic [EXP_W-1:0]     EMAX_F = '1;
   localparam logic [W-1:0]         QNAN   = {1'b0, EMAX_F, 1'b1, {(MAN_W-1){1'b0}}};

   logic                sa, sb, s_in;
   logic [EXP_W-1:0]    ea, eb;
   logic [MAN_W-1:0]    ma, mb;
   logic                za, zb, ia, ib, na, nb, snan;
   logic                spec_d, spec_inv_d;
   logic [W-1:0]        spec_res_d;

   assign {sa, ea, ma} = opA;
   assign {sb, eb, mb} = opB;
   assign s_in = sa ^ sb;
   assign za   = (ea == '0);
   assign zb   = (eb == '0);
   assign ia   = (ea == EMAX_F) && (ma == '0);
   assign ib   = (eb == EMAX_F) && (mb == '0);
   assign na   = (ea == EMAX_F) && (ma != '0);
   assign nb   = (eb == EMAX_F) && (mb != '0);
   assign snan = (na && !ma[MAN_W-1]) || (nb && !mb[MAN_W-1]);

   always_comb begin
      spec_d     = 1'b0;
      spec_inv_d = 1'b0;
      spec_res_d = '0;
      if (na || nb || (ia && zb) || (ib && za)) begin
         spec_d     = 1'b1;
         spec_res_d = QNAN;
         spec_inv_d = snan || (ia && zb) || (ib && za);
      end else if (ia || ib) begin
         spec_d     = 1'b1;
         spec_res_d = {s_in, EMAX_F, {MAN_W{1'b0}}};
      end else if (za || zb) begin
         spec_d     = 1'b1;
         spec_res_d = {s_in, {(W-1){1'b0}}};
      end
   end

   // Stage registers; only valids and the output stage carry reset.
   logic                v1, s1, spec1, spec_inv1;
   logic [W-1:0]        spec_res1;
   logic [EXP_W-1:0]    ea1, eb1;
   logic [PW-1:0]       p1;
   logic                v2, s2, spec2, spec_inv2, g2, st2;
   logic [W-1:0]        spec_res2;
   logic signed [SW-1:0] e2;
   logic [MAN_W-1:0]    m2;

   logic [PW-1:0]       pn;
   logic signed [SW-1:0] e_sum;
   assign pn    = p1[PW-1] ? p1 : (p1 << 1);
   assign e_sum = $signed({2'b00, ea1}) + $signed({2'b00, eb1}) - BIAS_S
                + $signed({{(SW-1){1'b0}}, p1[PW-1]});

   logic                rnd_up, ovf, unf;
   logic [MAN_W:0]      m_rnd;
   logic signed [SW-1:0] e_rnd;
`ifdef FP_MUL_RNE_EN
   assign rnd_up = g2 & (st2 | m2[0]);
`else
   assign rnd_up = 1'b0;
`endif
   assign m_rnd = {1'b0, m2} + {{MAN_W{1'b0}}, rnd_up};
   // A rounding carry leaves the stored mantissa all-zero, which is already the renormalised value.
   assign e_rnd = e2 + $signed({{(SW-1){1'b0}}, m_rnd[MAN_W]});
   assign ovf   = (e_rnd >= EMAX_S);
   assign unf   = (e_rnd <= ZERO_S);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (in_ready) begin
         s1        <= s_in;
         spec1     <= spec_d;
         spec_inv1 <= spec_inv_d;
         spec_res1 <= spec_res_d;
         ea1       <= ea;
         eb1       <= eb;
         p1        <= {{(MAN_W+1){1'b0}}, 1'b1, ma} * {{(MAN_W+1){1'b0}}, 1'b1, mb};
         s2        <= s1;
         spec2     <= spec1;
         spec_inv2 <= spec_inv1;
         spec_res2 <= spec_res1;
         e2        <= e_sum;
         m2        <= pn[PW-2 -: MAN_W];
         g2        <= pn[MAN_W];
         st2       <= |pn[MAN_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         product   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
         invalid   <= 1'b0;
      end else if (in_ready) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            if (spec2) begin
               product <= spec_res2;
               inexact <= 1'b0;
               invalid <= spec_inv2;
            end else if (ovf) begin
               product  <= {s2, EMAX_F, {MAN_W{1'b0}}};
               overflow <= 1'b1;
               inexact  <= 1'b1;
            end else if (unf) begin
               product   <= {s2, {(W-1){1'b0}}};
               underflow <= 1'b1;
               inexact   <= 1'b1;
            end else begin
               product <= {s2, e_rnd[EXP_W-1:0], m_rnd[MAN_W-1:0]};
               inexact <= g2 | st2;
            end
         end
      end
   end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe: bf16 instance (dut0) and fp16 instance (dut1) on shared inputs.
module tb_fp_mul_pipe;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, out_ready;
   logic [15:0] opA, opB;
   logic        in_ready0, out_valid0, ovf0, unf0, inx0, inv0;
   logic [15:0] product0;
   logic        in_ready1, out_valid1, ovf1, unf1, inx1, inv1;
   logic [15:0] product1;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(7)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .opA(opA), .opB(opB), .out_valid(out_valid0), .out_ready(out_ready),
      .product(product0), .overflow(ovf0), .underflow(unf0), .inexact(inx0), .invalid(inv0));

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .opA(opA), .opB(opB), .out_valid(out_valid1), .out_ready(out_ready),
      .product(product1), .overflow(ovf1), .underflow(unf1), .inexact(inx1), .invalid(inv1));

   // Stimulus only: issue one op on an idle pipe, return result, flags {ovf,unf,inx,inv} and latency (-1 on timeout).
   task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [3:0] fl, output int lat);
      int n;
      lat = -1;
      res = 'x;
      fl  = 'x;
      @(negedge clk);
      in_valid = 1'b1; opA = a; opB = b; out_ready = 1'b1;
      n = 0;
      #1;
      while (!(sel ? in_ready1 : in_ready0) && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (sel ? out_valid1 : out_valid0) begin
            lat = c;
            res = sel ? product1 : product0;
            fl  = sel ? {ovf1, unf1, inx1, inv1} : {ovf0, unf0, inx0, inv0};
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
      n_checks++;
      if (product0 !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h want 0000", product0); end
      n_checks++;
      if ({ovf0, unf0, inx0, inv0} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {ovf0, unf0, inx0, inv0});
      end
      n_checks++;
      if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
      n_checks++;
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_fp16: got %b want 0", out_valid1); end
   endtask

   task automatic test_basic;
      logic [15:0] r; logic [3:0] f; int lat;
      run_op(1'b0, 16'h3FC0, 16'h3FC0, r, f, lat);
      n_checks++;
      if (r !== 16'h4010) begin n_fail++; $display("FAIL basic_product: got %h want 4010", r); end
      n_checks++;
      if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b want 0000", f); end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", lat); end
   endtask

   task automatic test_tie_rounding;
      logic [15:0] r; logic [3:0] f; int lat;
      logic [15:0] want;
`ifdef FP_MUL_RNE_EN
      want = 16'h3FC2;
`else
      want = 16'h3FC1;
`endif
      run_op(1'b0, 16'h3F81, 16'h3FC0, r, f, lat);
      n_checks++;
      if (r !== want) begin n_fail++; $display("FAIL tie_product: got %h want %h", r, want); end
      n_checks++;
      if (f !== 4'b0010) begin n_fail++; $display("FAIL tie_flags: got %b want 0010", f); end
   endtask

   task automatic test_over_underflow;
      logic [15:0] r; logic [3:0] f; int lat;
      run_op(1'b0, 16'h7F00, 16'h4000, r, f, lat);
      n_checks++;
      if (r !== 16'h7F80) begin n_fail++; $display("FAIL ovf_product: got %h want 7F80", r); end
      n_checks++;
      if (f !== 4'b1010) begin n_fail++; $display("FAIL ovf_flags: got %b want 1010", f); end
      run_op(1'b0, 16'h0080, 16'h3F00, r, f, lat);
      n_checks++;
      if (r !== 16'h0000) begin n_fail++; $display("FAIL unf_product: got %h want 0000", r); end
      n_checks++;
      if (f !== 4'b0110) begin n_fail++; $display("FAIL unf_flags: got %b want 0110", f); end
   endtask

   task automatic test_specials;
      logic [15:0] va [3] = '{16'h7F80, 16'hFF80, 16'h7FC1};
      logic [15:0] vb [3] = '{16'h0000, 16'h4000, 16'h3F80};
      logic [15:0] vr [3] = '{16'h7FC0, 16'hFF80, 16'h7FC0};
      logic [3:0]  vf [3] = '{4'b0001, 4'b0000, 4'b0000};
      logic [15:0] r; logic [3:0] f; int lat;
      for (int k = 0; k < 3; k++) begin
         run_op(1'b0, va[k], vb[k], r, f, lat);
         n_checks++;
         if (r !== vr[k]) begin n_fail++; $display("FAIL special%0d_product: got %h want %h", k, r, vr[k]); end
         n_checks++;
         if (f !== vf[k]) begin n_fail++; $display("FAIL special%0d_flags: got %b want %b", k, f, vf[k]); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] vb   [6] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};
      logic [15:0] want [6] = '{16'h4080, 16'h40C0, 16'h4100, 16'h4120, 16'h4140, 16'h4160};
      logic [15:0] got [$];
      logic [15:0] held;
      bit          prev_stall;
      int          i, n_stall;
      i = 0; n_stall = 0; prev_stall = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
         @(negedge clk);
         in_valid  = (i < 6);
         opA       = 16'h4000;
         opB       = (i < 6) ? vb[i] : 16'h0000;
         out_ready = !(cyc >= 4 && cyc < 8);
         #1;
         if (out_valid0 && !out_ready) begin
            n_stall++;
            n_checks++;
            if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: cyc %0d got %b want 0", cyc, in_ready0); end
            if (prev_stall) begin
               n_checks++;
               if (product0 !== held) begin
                  n_fail++; $display("FAIL stall_hold: cyc %0d got %h want %h", cyc, product0, held);
               end
            end
            held = product0;
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (in_valid && in_ready0) i++;
         if (out_valid0 && out_ready) got.push_back(product0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (n_stall !== 4) begin n_fail++; $display("FAIL stall_cycles: got %0d want 4", n_stall); end
      n_checks++;
      if (got.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got.size()); end
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (k >= got.size()) begin
            n_fail++; $display("FAIL b2b_result%0d: got none want %h", k, want[k]);
         end else if (got[k] !== want[k]) begin
            n_fail++; $display("FAIL b2b_result%0d: got %h want %h", k, got[k], want[k]);
         end
      end
   endtask

   task automatic test_reset_midflight;
      int stale;
      stale = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; opA = 16'h3F80; opB = 16'h4000 + 16'(k); out_ready = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin
         n_fail++; $display("FAIL midflight_full: out_valid %b in_ready %b want 1 0", out_valid0, in_ready0);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL midflight_out_valid: got %b want 0", out_valid0); end
      n_checks++;
      if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL midflight_in_ready: got %b want 1", in_ready0); end
      n_checks++;
      if (product0 !== 16'h0000) begin n_fail++; $display("FAIL midflight_product: got %h want 0000", product0); end
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (out_valid0 || out_valid1) stale++;
      end
      n_checks++;
      if (stale !== 0) begin n_fail++; $display("FAIL midflight_stale: got %0d stale results want 0", stale); end
   endtask

   task automatic test_fp16;
      logic [15:0] r; logic [3:0] f; int lat;
      run_op(1'b1, 16'h3C00, 16'h4000, r, f, lat);
      n_checks++;
      if (r !== 16'h4000) begin n_fail++; $display("FAIL fp16_product: got %h want 4000", r); end
      n_checks++;
      if (f !== 4'b0000) begin n_fail++; $display("FAIL fp16_flags: got %b want 0000", f); end
      n_checks++;
      if (lat !== 3) begin n_fail++; $display("FAIL fp16_latency: got %0d want 3", lat); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opA = '0; opB = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_basic();
      test_tie_rounding();
      test_over_underflow();
      test_specials();
      test_back_to_back();
      test_reset_midflight();
      test_fp16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
